// File: rtl/temp_averager.sv
// Moving-average filter over the last 2**DEPTH_LOG2 temperature samples.
// Each accepted sample takes three cycles (IDLE -> SUM -> OUT); the average
// is saturated to 0..63 for a two-digit display and pulsed on avg_valid.
module temp_averager #(
    parameter int SAMPLE_W   = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic [5:0]          avg,
    output logic                avg_valid,
    output logic                avg_ovf,
    output logic                window_full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SUM_W = SAMPLE_W + DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, SUM, OUT} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [SAMPLE_W-1:0]   buffer [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      quotient;
    logic [SAMPLE_W-1:0]   new_s;
    logic [SAMPLE_W-1:0]   oldest;
    logic                  accept;
    logic                  full;

    assign full         = (count == CNT_W'(DEPTH));
    assign sample_ready = (state == IDLE) && !clear;
    assign accept       = sample_ready && sample_valid;
    assign quotient     = sum >> DEPTH_LOG2;

    // Next-state sequencing: one sample walks IDLE -> SUM -> OUT -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SUM;
            SUM:     state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; clear flushes back to IDLE just like reset.
    always_ff @(posedge clk) begin
        if (rst || clear) state <= IDLE;
        else              state <= state_nxt;
    end

    // Sample buffer and per-sample operands; the evicted sample is captured
    // before the slot is overwritten, and counts as zero until the window is full.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            buffer[wr_ptr] <= sample;
            new_s          <= sample;
            oldest         <= full ? buffer[wr_ptr] : '0;
        end
    end

    // Running sum, pointers and the saturated average output.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum         <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            avg         <= '0;
            avg_ovf     <= 1'b0;
            avg_valid   <= 1'b0;
            window_full <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            case (state)
                SUM: begin
                    // Modular add-then-subtract; the final sum always fits SUM_W.
                    sum         <= sum + SUM_W'(new_s) - SUM_W'(oldest);
                    wr_ptr      <= wr_ptr + DEPTH_LOG2'(1);
                    if (!full) count <= count + CNT_W'(1);
                    window_full <= full || (count == CNT_W'(DEPTH - 1));
                end
                OUT: begin
                    if (full) begin
                        avg_valid <= 1'b1;
                        avg_ovf   <= (quotient > SUM_W'(63));
                        avg       <= (quotient > SUM_W'(63)) ? 6'd63 : quotient[5:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_averager.sv
// Scoreboard bench for temp_averager: a queue-based window model predicts
// every avg_valid pulse (value, overflow flag and cycle); a negedge monitor
// pops and compares, and also checks handshake and output hold behaviour.
module tb_temp_averager;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [7:0] sample = '0;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic [5:0] avg;
    logic       avg_valid;
    logic       avg_ovf;
    logic       window_full;

    temp_averager #(.SAMPLE_W(8), .DEPTH_LOG2(3)) dut (
        .clk(clk), .rst(rst), .clear(clear), .sample(sample),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .avg(avg), .avg_valid(avg_valid), .avg_ovf(avg_ovf),
        .window_full(window_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int avg;
        int ovf;
        int cyc;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cnt  = 0;
    int   busy     = 0;
    int   m_avg    = 0;
    int   m_ovf    = 0;
    int   window[$];
    exp_t expq[$];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model + monitor, evaluated at the negedge with the inputs the
    // next rising edge will see.
    always @(negedge clk) begin
        exp_t e;
        int   s;
        int   q;
        cyc++;
        if (rst) begin
            window.delete();
            expq.delete();
            busy  = 0;
            m_avg = 0;
            m_ovf = 0;
        end else begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                check("missed_pulse", 0, 1);
                void'(expq.pop_front());
            end
            if (avg_valid) begin
                if (expq.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("avg", int'(avg), e.avg);
                    check("avg_ovf", int'(avg_ovf), e.ovf);
                    check("window_full_at_pulse", int'(window_full), 1);
                    m_avg = e.avg;
                    m_ovf = e.ovf;
                end
            end else begin
                check("avg_hold", int'(avg), m_avg);
                check("avg_ovf_hold", int'(avg_ovf), m_ovf);
            end
            check("sample_ready", int'(sample_ready), (busy == 0 && !clear) ? 1 : 0);
            if (clear) begin
                window.delete();
                expq.delete();
                busy  = 0;
                m_avg = 0;
                m_ovf = 0;
            end else if (busy == 0 && sample_valid) begin
                acc_cnt++;
                busy = 2;
                window.push_back(int'(sample));
                if (window.size() > 8) void'(window.pop_front());
                if (window.size() == 8) begin
                    s = 0;
                    foreach (window[i]) s += window[i];
                    q = s / 8;
                    e.avg = (q > 63) ? 63 : q;
                    e.ovf = (q > 63) ? 1 : 0;
                    e.cyc = cyc + 3;
                    expq.push_back(e);
                end
            end else if (busy > 0) begin
                busy--;
            end
        end
    end

    task automatic wait_cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        int start;
        int t;
        start        = acc_cnt;
        t            = 0;
        sample       = 8'(v);
        sample_valid = 1'b1;
        while (acc_cnt == start && t < 50) begin
            @(posedge clk);
            t++;
        end
        if (acc_cnt == start) check("accept_timeout", 0, 1);
        #1 sample_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        wait_cycles(1);
        clear = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        check("reset_ready", int'(sample_ready), 1);
        check("reset_avg", int'(avg), 0);
        check("reset_avg_valid", int'(avg_valid), 0);
        check("reset_avg_ovf", int'(avg_ovf), 0);
        check("reset_window_full", int'(window_full), 0);

        // Fill with 25, then slide in 33
        for (int i = 0; i < 8; i++) send(25);
        wait_cycles(4);
        check("fill_avg", int'(avg), 25);
        check("fill_window_full", int'(window_full), 1);
        send(33);
        wait_cycles(4);
        check("slide_avg", int'(avg), 26);

        // Saturation and recovery
        do_clear();
        check("clear_window_full", int'(window_full), 0);
        for (int i = 0; i < 8; i++) send(100);
        wait_cycles(4);
        check("sat_avg", int'(avg), 63);
        check("sat_ovf", int'(avg_ovf), 1);
        for (int i = 0; i < 8; i++) send(10);
        wait_cycles(4);
        check("unsat_avg", int'(avg), 10);
        check("unsat_ovf", int'(avg_ovf), 0);

        // Pointer wrap
        do_clear();
        for (int i = 0; i < 20; i++) send(i);
        wait_cycles(4);
        check("wrap_avg", int'(avg), 15);

        // Clear during SUM of the 8th sample
        do_clear();
        for (int i = 0; i < 7; i++) send(5);
        send(5);
        do_clear();
        wait_cycles(4);
        check("midclear_avg", int'(avg), 0);
        check("midclear_window_full", int'(window_full), 0);
        for (int i = 0; i < 7; i++) send(7);
        wait_cycles(4);
        check("refill7_window_full", int'(window_full), 0);
        send(7);
        wait_cycles(4);
        check("refill8_avg", int'(avg), 7);

        // Reset during OUT aborts the pending result
        send(9);
        wait_cycles(1);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(4);
        check("midrst_avg", int'(avg), 0);
        check("midrst_window_full", int'(window_full), 0);
        check("midrst_ready", int'(sample_ready), 1);

        // Randomized traffic with gaps and occasional clears
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r == 0) do_clear();
            else if (r < 6) wait_cycles($urandom_range(1, 4));
            if ($urandom_range(0, 1) == 0) send($urandom_range(0, 80));
            else send($urandom_range(0, 255));
        end

        wait_cycles(10);
        check("scoreboard_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
